// File: rtl/sdio_rbuf_rd.sv
// Sys-clock reader for the SDIO read buffer: drains the ping-pong banks in order,
// streams bytes over valid/ready and hands each emptied bank back to the SD side.
module sdio_rbuf_rd #(
  parameter int BUF_AW = 9,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [BUF_AW:0]   blk_len,
  input  logic [CNT_W-1:0]  blk_cnt,
  input  logic              buf0_rd_rdy_sys,
  input  logic              buf1_rd_rdy_sys,
  output logic              buf_rd_en,
  output logic [BUF_AW:0]   buf_rd_addr,
  input  logic [7:0]        buf_rd_data,
  output logic [7:0]        dma_data,
  output logic              dma_vld,
  input  logic              dma_rdy,
  output logic              buf_free_sys,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_LOAD, S_SEND, S_FREE, S_FIN
  } state_t;

  localparam logic [BUF_AW:0]  LEN_ONE = {{BUF_AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [BUF_AW:0]   len_r;
  logic [BUF_AW:0]   ofs;
  logic [CNT_W-1:0]  blk_rem;
  logic              bnk;
  logic [1:0]        hold;
  logic [1:0]        rdy;
  logic              bank_ok;
  logic              last_byte;
  logic [BUF_AW-1:0] ofs_inc;

  assign rdy       = {buf1_rd_rdy_sys, buf0_rd_rdy_sys};
  assign bank_ok   = rdy[bnk] & ~hold[bnk];
  // Full-width compare so a 2^BUF_AW block ends at all-ones without touching the bank bit.
  assign last_byte = (ofs == (len_r - LEN_ONE));
  assign ofs_inc   = ofs[BUF_AW-1:0] + 1'b1;

  // A just-freed bank keeps its ready level for a few cycles through the synchronizer;
  // hold masks it until the level has been seen low once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state == S_FREE && bnk == 1'(i)) begin
          hold[i] <= 1'b1;
        end else if (!rdy[i]) begin
          hold[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      len_r        <= '0;
      ofs          <= '0;
      blk_rem      <= '0;
      bnk          <= 1'b0;
      buf_rd_en    <= 1'b0;
      buf_rd_addr  <= '0;
      dma_data     <= '0;
      dma_vld      <= 1'b0;
      buf_free_sys <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      buf_rd_en    <= 1'b0;
      buf_free_sys <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (blk_cnt == '0) begin
              done <= 1'b1;
            end else begin
              len_r   <= blk_len;
              blk_rem <= blk_cnt;
              ofs     <= '0;
              busy    <= 1'b1;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bank_ok) begin
            buf_rd_en   <= 1'b1;
            buf_rd_addr <= {bnk, ofs[BUF_AW-1:0]};
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          dma_data <= buf_rd_data;
          dma_vld  <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          // dma_vld is high for the whole of SEND, so dma_rdy alone marks acceptance.
          if (dma_rdy) begin
            dma_vld <= 1'b0;
            if (last_byte) begin
              buf_free_sys <= 1'b1;
              state        <= S_FREE;
            end else begin
              ofs         <= {1'b0, ofs_inc};
              buf_rd_en   <= 1'b1;
              buf_rd_addr <= {bnk, ofs_inc};
              state       <= S_FETCH;
            end
          end
        end
        S_FREE: begin
          bnk     <= ~bnk;
          ofs     <= '0;
          blk_rem <= blk_rem - CNT_ONE;
          if (blk_rem == CNT_ONE) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            state <= S_WAIT;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
